// File: rtl/issue_pkg.sv
// issue_pkg: types and constants shared by decode, the issue window and the
// cross-lane dependency checker.
//   ISSUE_NUM_WIDTH      issue/enqueue lanes per cycle
//   ISSUE_RD_WIDTH       destination register index width
//   ISSUE_RS_WIDTH       source register index width
//   ISSUE_PAYLOAD_WIDTH  opaque decoded-instruction payload width
//   ISSUE_DEPTH          issue window entry count (power of two)
//   issue_entry_t        one buffered instruction {rd, rs1, rs2, payload}
package issue_pkg;

  localparam int ISSUE_NUM_WIDTH     = 3;
  localparam int ISSUE_RD_WIDTH      = 5;
  localparam int ISSUE_RS_WIDTH      = 5;
  localparam int ISSUE_PAYLOAD_WIDTH = 32;
  localparam int ISSUE_DEPTH         = 8;

  typedef struct packed {
    logic [ISSUE_RD_WIDTH-1:0]      rd;
    logic [ISSUE_RS_WIDTH-1:0]      rs1;
    logic [ISSUE_RS_WIDTH-1:0]      rs2;
    logic [ISSUE_PAYLOAD_WIDTH-1:0] payload;
  } issue_entry_t;

endpackage

// File: rtl/issue_prefix_len.sv
// issue_prefix_len: leading-ones count over (valid & grant), gated by enable.
//   valid   per-lane occupancy
//   grant   per-lane permission (can_issue, or all ones for enqueue)
//   enable  global gate; when low the prefix is empty
//   len     number of leading lanes that pass
//   mask    the same prefix as a lane mask (always contiguous from lane 0)
module issue_prefix_len #(
  parameter int NUM_WIDTH = 3,
  parameter int CNT_W     = $clog2(NUM_WIDTH + 1)
) (
  input  logic [NUM_WIDTH-1:0] valid,
  input  logic [NUM_WIDTH-1:0] grant,
  input  logic                 enable,
  output logic [CNT_W-1:0]     len,
  output logic [NUM_WIDTH-1:0] mask
);

  always_comb begin
    logic run;
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned (no latch); blocking '=' lets 'run' carry lane to lane.
    run  = enable;
    len  = '0;
    mask = '0;
    for (int i = 0; i < NUM_WIDTH; i++) begin
      run     = run & valid[i] & grant[i];
      mask[i] = run;
      if (run) len = CNT_W'(i + 1);
    end
  end

endmodule

// File: rtl/issue_window.sv
// issue_window: in-order issue buffer. Decode enqueues up to NUM_WIDTH
// instructions per cycle; the oldest NUM_WIDTH entries are presented as a
// window to the dependency checker, and the longest issuable prefix is issued
// and retired from the head in the same cycle.
//   clk, rst_n         clock, synchronous active-low reset
//   flush              drop all entries (wins over enqueue and issue)
//   enq_valid/rd/rs1/rs2/payload, enq_ready   decode side
//   win_valid/rd/rs1/rs2                      window to the checker
//   can_issue, iss_ready                      checker mask, execute ready
//   iss_valid/payload/count                   issued prefix
//   count                                     occupied entries
// Width parameters default to issue_pkg; storage uses issue_entry_t, so they
// are overridden only together with the package.
module issue_window
  import issue_pkg::*;
#(
  parameter int NUM_WIDTH     = ISSUE_NUM_WIDTH,
  parameter int RD_WIDTH      = ISSUE_RD_WIDTH,
  parameter int RS_WIDTH      = ISSUE_RS_WIDTH,
  parameter int PAYLOAD_WIDTH = ISSUE_PAYLOAD_WIDTH,
  parameter int DEPTH         = ISSUE_DEPTH
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     flush,
  input  logic [NUM_WIDTH-1:0]                     enq_valid,
  input  logic [NUM_WIDTH-1:0][RD_WIDTH-1:0]       enq_rd,
  input  logic [NUM_WIDTH-1:0][RS_WIDTH-1:0]       enq_rs1,
  input  logic [NUM_WIDTH-1:0][RS_WIDTH-1:0]       enq_rs2,
  input  logic [NUM_WIDTH-1:0][PAYLOAD_WIDTH-1:0]  enq_payload,
  output logic                                     enq_ready,
  output logic [NUM_WIDTH-1:0]                     win_valid,
  output logic [NUM_WIDTH-1:0][RD_WIDTH-1:0]       win_rd,
  output logic [NUM_WIDTH-1:0][RS_WIDTH-1:0]       win_rs1,
  output logic [NUM_WIDTH-1:0][RS_WIDTH-1:0]       win_rs2,
  input  logic [NUM_WIDTH-1:0]                     can_issue,
  input  logic                                     iss_ready,
  output logic [NUM_WIDTH-1:0]                     iss_valid,
  output logic [NUM_WIDTH-1:0][PAYLOAD_WIDTH-1:0]  iss_payload,
  output logic [$clog2(NUM_WIDTH+1)-1:0]           iss_count,
  output logic [$clog2(DEPTH+1)-1:0]               count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ISS_W = $clog2(NUM_WIDTH + 1);

  // DEPTH is a power of two, so plain PTR_W-bit addition wraps modulo DEPTH.
  // No wrap bit: count tells full from empty.
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  issue_entry_t         mem [DEPTH];

  logic [ISS_W-1:0]     enq_len;
  logic [NUM_WIDTH-1:0] enq_mask;

  // Built from the registered count only; a same-cycle issue never raises it.
  assign enq_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(NUM_WIDTH);

  // Window: lane i is entry head+i. Empty lanes drive zero indices so the
  // checker never sees a phantom hazard.
  always_comb begin
    for (int i = 0; i < NUM_WIDTH; i++) begin
      win_valid[i]   = CNT_W'(i) < count;
      win_rd[i]      = win_valid[i] ? mem[head + PTR_W'(i)].rd  : '0;
      win_rs1[i]     = win_valid[i] ? mem[head + PTR_W'(i)].rs1 : '0;
      win_rs2[i]     = win_valid[i] ? mem[head + PTR_W'(i)].rs2 : '0;
      iss_payload[i] = mem[head + PTR_W'(i)].payload;
    end
  end

  issue_prefix_len #(.NUM_WIDTH(NUM_WIDTH), .CNT_W(ISS_W)) u_iss_prefix (
    .valid  (win_valid),
    .grant  (can_issue),
    .enable (iss_ready),
    .len    (iss_count),
    .mask   (iss_valid)
  );

  // Enqueue takes the leading run of enq_valid, and only when a full bundle fits.
  issue_prefix_len #(.NUM_WIDTH(NUM_WIDTH), .CNT_W(ISS_W)) u_enq_prefix (
    .valid  (enq_valid),
    .grant  ({NUM_WIDTH{1'b1}}),
    .enable (enq_ready),
    .len    (enq_len),
    .mask   (enq_mask)
  );

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(iss_count);
      tail  <= tail + PTR_W'(enq_len);
      count <= count + CNT_W'(enq_len) - CNT_W'(iss_count);
    end
  end

  // NOTE: the entry array is deliberately not reset; count gates every read
  // that matters, so clearing it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      for (int i = 0; i < NUM_WIDTH; i++) begin
        if (enq_mask[i]) begin
          mem[tail + PTR_W'(i)] <= '{rd:      enq_rd[i],
                                     rs1:     enq_rs1[i],
                                     rs2:     enq_rs2[i],
                                     payload: enq_payload[i]};
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_window.sv
module tb_issue_window;
  import issue_pkg::*;

  localparam int NW    = 3;
  localparam int DEPTH = 8;

  logic                clk;
  logic                rst_n;
  logic                flush;
  logic [NW-1:0]       enq_valid;
  logic [NW-1:0][4:0]  enq_rd;
  logic [NW-1:0][4:0]  enq_rs1;
  logic [NW-1:0][4:0]  enq_rs2;
  logic [NW-1:0][31:0] enq_payload;
  logic                enq_ready;
  logic [NW-1:0]       win_valid;
  logic [NW-1:0][4:0]  win_rd;
  logic [NW-1:0][4:0]  win_rs1;
  logic [NW-1:0][4:0]  win_rs2;
  logic [NW-1:0]       can_issue;
  logic                iss_ready;
  logic [NW-1:0]       iss_valid;
  logic [NW-1:0][31:0] iss_payload;
  logic [1:0]          iss_count;
  logic [3:0]          count;

  int checks   = 0;
  int failures = 0;

  issue_window dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .enq_valid   (enq_valid),
    .enq_rd      (enq_rd),
    .enq_rs1     (enq_rs1),
    .enq_rs2     (enq_rs2),
    .enq_payload (enq_payload),
    .enq_ready   (enq_ready),
    .win_valid   (win_valid),
    .win_rd      (win_rd),
    .win_rs1     (win_rs1),
    .win_rs2     (win_rs2),
    .can_issue   (can_issue),
    .iss_ready   (iss_ready),
    .iss_valid   (iss_valid),
    .iss_payload (iss_payload),
    .iss_count   (iss_count),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Directed vector: inputs for one cycle plus the outputs expected in that
  // cycle (before the edge that applies it).
  typedef struct {
    logic       rst_n;
    logic       flush;
    logic [2:0] ev;
    logic [14:0] rd;
    logic [14:0] rs1;
    logic [2:0] can;
    logic       ir;
    int         cnt;
    logic [2:0] wv;
    int         ic;
    logic       er;
    int         rd0;
    int         rs1_0;
  } vec_t;

  function automatic vec_t v(input logic rn, input logic fl, input logic [2:0] ev,
                             input logic [14:0] rd, input logic [14:0] rs1,
                             input logic [2:0] can, input logic ir, input int cnt,
                             input logic [2:0] wv, input int ic, input logic er,
                             input int rd0, input int rs1_0);
    vec_t r;
    r.rst_n = rn; r.flush = fl; r.ev = ev; r.rd = rd; r.rs1 = rs1;
    r.can = can; r.ir = ir; r.cnt = cnt; r.wv = wv; r.ic = ic; r.er = er;
    r.rd0 = rd0; r.rs1_0 = rs1_0;
    return r;
  endfunction

  typedef struct {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] pl;
  } ent_t;

  vec_t tbl[23];
  ent_t q[$];

  initial begin
    logic [14:0] z;
    z = '0;
    // independent bundle
    tbl[0]  = v(1, 0, 3'b111, {5'd3, 5'd2, 5'd1}, z, 3'b111, 1, 0, 3'b000, 0, 1, 0, 0);
    tbl[1]  = v(1, 0, 3'b000, z, z, 3'b111, 1, 3, 3'b111, 3, 1, 1, 0);
    // dependency stall: checker passes lane 0 only
    tbl[2]  = v(1, 0, 3'b111, {5'd7, 5'd6, 5'd5}, {5'd0, 5'd5, 5'd0}, 3'b111, 1, 0, 3'b000, 0, 1, 0, 0);
    tbl[3]  = v(1, 0, 3'b111, {5'd10, 5'd9, 5'd8}, z, 3'b001, 1, 3, 3'b111, 1, 1, 5, 0);
    tbl[4]  = v(1, 0, 3'b000, z, z, 3'b000, 1, 5, 3'b111, 0, 1, 6, 5);
    // flush with a bundle present; issue still visible that cycle
    tbl[5]  = v(1, 1, 3'b111, {5'd1, 5'd1, 5'd1}, z, 3'b111, 1, 5, 3'b111, 3, 1, 6, 5);
    tbl[6]  = v(1, 0, 3'b000, z, z, 3'b111, 1, 0, 3'b000, 0, 1, 0, 0);
    // backpressure: fill to 6, held bundle waits
    tbl[7]  = v(1, 0, 3'b111, {5'd13, 5'd12, 5'd11}, z, 3'b111, 0, 0, 3'b000, 0, 1, 0, 0);
    tbl[8]  = v(1, 0, 3'b111, {5'd16, 5'd15, 5'd14}, z, 3'b111, 0, 3, 3'b111, 0, 1, 11, 0);
    tbl[9]  = v(1, 0, 3'b111, {5'd19, 5'd18, 5'd17}, z, 3'b111, 0, 6, 3'b111, 0, 0, 11, 0);
    tbl[10] = v(1, 0, 3'b111, {5'd19, 5'd18, 5'd17}, z, 3'b111, 0, 6, 3'b111, 0, 0, 11, 0);
    tbl[11] = v(1, 0, 3'b111, {5'd19, 5'd18, 5'd17}, z, 3'b001, 1, 6, 3'b111, 1, 0, 11, 0);
    tbl[12] = v(1, 0, 3'b111, {5'd19, 5'd18, 5'd17}, z, 3'b111, 0, 5, 3'b111, 0, 1, 12, 0);
    tbl[13] = v(1, 0, 3'b000, z, z, 3'b111, 0, 8, 3'b111, 0, 0, 12, 0);
    tbl[14] = v(1, 0, 3'b000, z, z, 3'b111, 1, 8, 3'b111, 3, 0, 12, 0);
    // non-contiguous enq_valid: only lane 0 lands
    tbl[15] = v(1, 0, 3'b101, {5'd22, 5'd21, 5'd20}, z, 3'b111, 0, 5, 3'b111, 0, 1, 15, 0);
    tbl[16] = v(1, 0, 3'b000, z, z, 3'b111, 1, 6, 3'b111, 3, 0, 15, 0);
    tbl[17] = v(1, 0, 3'b000, z, z, 3'b111, 1, 3, 3'b111, 3, 1, 18, 0);
    // mid-operation reset with a full window
    tbl[18] = v(1, 0, 3'b111, {5'd25, 5'd24, 5'd23}, z, 3'b111, 0, 0, 3'b000, 0, 1, 0, 0);
    tbl[19] = v(1, 0, 3'b111, {5'd28, 5'd27, 5'd26}, z, 3'b111, 0, 3, 3'b111, 0, 1, 23, 0);
    tbl[20] = v(1, 0, 3'b111, {5'd31, 5'd30, 5'd29}, z, 3'b111, 0, 6, 3'b111, 0, 0, 23, 0);
    tbl[21] = v(0, 0, 3'b111, {5'd31, 5'd30, 5'd29}, z, 3'b111, 0, 6, 3'b111, 0, 0, 23, 0);
    tbl[22] = v(1, 0, 3'b000, z, z, 3'b111, 1, 0, 3'b000, 0, 1, 0, 0);

    // reset with garbage on the inputs
    rst_n = 1'b0; flush = 1'b0; enq_valid = 3'b111; can_issue = 3'b111; iss_ready = 1'b1;
    enq_rd = '1; enq_rs1 = '1; enq_rs2 = '1; enq_payload = '1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; enq_valid = '0;
    @(negedge clk);
    check("reset count", count, 0);
    check("reset win_valid", win_valid, 0);
    check("reset win_rd", win_rd, 0);
    check("reset win_rs1", win_rs1, 0);
    check("reset win_rs2", win_rs2, 0);
    check("reset iss_valid", iss_valid, 0);
    check("reset iss_count", iss_count, 0);
    check("reset enq_ready", enq_ready, 1);
    @(posedge clk);
    #1;

    for (int k = 0; k < 23; k++) begin
      rst_n     = tbl[k].rst_n;
      flush     = tbl[k].flush;
      enq_valid = tbl[k].ev;
      enq_rd    = tbl[k].rd;
      enq_rs1   = tbl[k].rs1;
      enq_rs2   = '0;
      can_issue = tbl[k].can;
      iss_ready = tbl[k].ir;
      for (int l = 0; l < NW; l++) enq_payload[l] = 32'(k * 4 + l);
      @(negedge clk);
      check($sformatf("vec%0d count", k), count, tbl[k].cnt);
      check($sformatf("vec%0d win_valid", k), win_valid, tbl[k].wv);
      check($sformatf("vec%0d iss_count", k), iss_count, tbl[k].ic);
      check($sformatf("vec%0d enq_ready", k), enq_ready, tbl[k].er);
      check($sformatf("vec%0d win_rd0", k), win_rd[0], tbl[k].rd0);
      check($sformatf("vec%0d win_rs1_0", k), win_rs1[0], tbl[k].rs1_0);
      @(posedge clk);
      #1;
    end

    // Randomized phase against a queue model; starts empty after vec22.
    rst_n = 1'b1;
    q.delete();
    for (int cyc = 0; cyc < 300; cyc++) begin
      int sz, n, m;
      logic [NW-1:0]      e_wv, e_iv;
      logic [NW-1:0][4:0] e_rd, e_rs1, e_rs2;
      logic               e_er;

      flush     = ($urandom_range(0, 39) == 0);
      enq_valid = 3'($urandom);
      can_issue = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'($urandom);
      iss_ready = ($urandom_range(0, 3) != 0);
      for (int l = 0; l < NW; l++) begin
        enq_rd[l]      = 5'($urandom);
        enq_rs1[l]     = 5'($urandom);
        enq_rs2[l]     = 5'($urandom);
        enq_payload[l] = 32'h1000 + 32'(cyc * 4 + l);
      end
      @(negedge clk);

      sz   = q.size();
      e_er = (DEPTH - sz) >= NW;
      n = 0;
      if (iss_ready)
        for (int i = 0; i < NW; i++) begin
          if (i < sz && can_issue[i]) n++;
          else break;
        end
      m = 0;
      if (e_er)
        for (int i = 0; i < NW; i++) begin
          if (enq_valid[i]) m++;
          else break;
        end
      for (int i = 0; i < NW; i++) begin
        e_wv[i]  = (i < sz);
        e_iv[i]  = (i < n);
        e_rd[i]  = (i < sz) ? q[i].rd  : 5'd0;
        e_rs1[i] = (i < sz) ? q[i].rs1 : 5'd0;
        e_rs2[i] = (i < sz) ? q[i].rs2 : 5'd0;
      end

      check($sformatf("rnd%0d count", cyc), count, sz);
      check($sformatf("rnd%0d enq_ready", cyc), enq_ready, e_er);
      check($sformatf("rnd%0d win_valid", cyc), win_valid, e_wv);
      check($sformatf("rnd%0d win_rd", cyc), win_rd, e_rd);
      check($sformatf("rnd%0d win_rs1", cyc), win_rs1, e_rs1);
      check($sformatf("rnd%0d win_rs2", cyc), win_rs2, e_rs2);
      check($sformatf("rnd%0d iss_valid", cyc), iss_valid, e_iv);
      check($sformatf("rnd%0d iss_count", cyc), iss_count, n);
      for (int i = 0; i < n; i++)
        check($sformatf("rnd%0d iss_payload%0d", cyc, i), iss_payload[i], q[i].pl);

      if (flush) begin
        q.delete();
      end else begin
        repeat (n) void'(q.pop_front());
        for (int i = 0; i < m; i++)
          q.push_back('{rd: enq_rd[i], rs1: enq_rs1[i], rs2: enq_rs2[i], pl: enq_payload[i]});
      end
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/issue_window.md
# issue_window

In-order issue buffer for the superscalar front end. Decode pushes bundles of up to NUM_WIDTH instructions into it. Each cycle it presents its oldest NUM_WIDTH entries as a register window to the cross-lane dependency checker. It takes back the checker's per-lane can_issue mask, issues the longest contiguous issuable prefix to execute, and retires exactly those entries from the head.

## Interface
Parameters:
- NUM_WIDTH, 3, issue/enqueue lanes per cycle
- RD_WIDTH, 5, destination register index width
- RS_WIDTH, 5, source register index width
- PAYLOAD_WIDTH, 32, opaque decoded-instruction payload width
- DEPTH, 8, entry count; power of two, ≥ 2*NUM_WIDTH

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  drop all entries
- enq_valid  in  [NUM_WIDTH]  per-lane valid from decode
- enq_rd / enq_rs1 / enq_rs2  in  [NUM_WIDTH] x RD_WIDTH / RS_WIDTH / RS_WIDTH  register indices
- enq_payload  in  [NUM_WIDTH] x PAYLOAD_WIDTH  payload
- enq_ready  out  1  window can accept a full bundle
- win_valid  out  [NUM_WIDTH]  window lane holds a live entry
- win_rd / win_rs1 / win_rs2  out  per-lane indices to the dependency checker
- can_issue  in  [NUM_WIDTH]  mask returned by the dependency checker
- iss_ready  in  1  execute accepts issue this cycle
- iss_valid  out  [NUM_WIDTH]  lanes issued this cycle (always a prefix)
- iss_payload  out  [NUM_WIDTH] x PAYLOAD_WIDTH  payload of window lanes
- iss_count  out  $clog2(NUM_WIDTH+1)  number of lanes issued
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Storage: circular array of DEPTH entries {rd, rs1, rs2, payload}. Registers: head, tail (both mod DEPTH), count.
- Window lane i maps to entry (head+i) mod DEPTH. win_valid[i] = (i < count).
- Invalid window lanes drive win_rd = win_rs1 = win_rs2 = 0, so they never create a false hazard.
- Issue length n counts leading lanes i with win_valid[i] && can_issue[i], stopping at the first failure.
- n = 0 when iss_ready = 0 or when can_issue[0] = 0.
- iss_valid[i] = (i < n). iss_count = n.
- Enqueue:
  - enq_ready = (DEPTH − count ≥ NUM_WIDTH). It is computed from the registered count only; same-cycle issue does not raise it.
  - Lanes written = leading contiguous 1s of enq_valid. Lanes after the first 0 are ignored.
  - Writes occur only when enq_ready = 1; otherwise the bundle is not consumed.
  - Lanes are written to tail, tail+1, … mod DEPTH.
- Update each edge: head += n; tail += m; count += m − n (m = lanes written).
- flush: head = tail = count = 0 next edge. flush has priority over enqueue and issue; the same-cycle bundle is dropped. iss_valid is still driven combinationally in the flush cycle and is valid.
- Reset (rst_n = 0 at an edge): same effect as flush. It overrides any in-progress enqueue or issue.

## Timing
- Reset values: count = 0, win_valid = 0, window indices = 0, iss_valid = 0, iss_count = 0, enq_ready = 1.
- Enqueue-to-window latency is 1 cycle; there is no bypass of the enqueue inputs into the window.
- Window → checker → iss_valid is combinational within one cycle; the retire takes effect at the following edge.
- The window re-presents un-issued entries next cycle at lane 0 onward, with younger entries shifted in behind them.
- Pointer wrap is modular; pointers carry no extra wrap bit because count disambiguates full from empty.
- Simultaneous enqueue and issue in one cycle are both applied.

## Structure
- Package issue_pkg holds:
  - the typedef struct issue_entry_t {rd, rs1, rs2, payload};
  - the shared NUM_WIDTH / register-width constants, also used by decode and the dependency checker.
- Sub-module issue_prefix_len: combinational leading-ones count over (win_valid & can_issue), gated by iss_ready. It outputs n and the prefix mask.
- Checker instantiation stays at the parent level; this block only exposes the window ports.

## Test plan
- **Independent bundle:** reset; enqueue rd = 1,2,3 with rs = 0; tie can_issue = 111, iss_ready = 1. Next cycle win_valid = 111, iss_count = 3; following cycle count = 0.
- **Dependency stall:** enqueue {rd5}, {rs1=5, rd6}, {rd7}; checker returns 100. iss_count = 1. Next cycle lane 0 shows the rs1=5 entry and win_valid = 11x. count = 3 − 1 + new.
- **Full/backpressure:** iss_ready = 0; enqueue 3 per cycle. count goes 3 → 6; enq_ready = 0 at count 6. The held bundle stays un-consumed until issue frees ≥ 1.
- **Wrap-around:** drive 20 enqueue/issue cycles with mixed masks. Issued payload sequence exactly matches enqueue order across the index 7 → 0 boundary.
- **Flush with enqueue:** count = 5, flush = 1, enq_valid = 111. Next cycle count = 0, win_valid = 000, enq_ready = 1.
- **Non-contiguous enq_valid = 101 / mid-op reset:** only lane 0 is written (count + 1). rst_n = 0 with a full window gives all reset values next cycle.
